// File: rtl/opseq_pkg.sv
// Shared state encoding and default sizing for the operand sequencer slice.
package opseq_pkg;

  localparam int unsigned DEF_DATA_W      = 16;
  localparam int unsigned DEF_RES_W       = 32;
  localparam int unsigned DEF_DEPTH       = 4;
  localparam int unsigned DEF_TIMEOUT_CYC = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } opseq_state_t;

endpackage

// File: rtl/opseq_if.sv
// Operand input stream, core start/done link and result output stream.
interface opseq_if
  import opseq_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned RES_W  = DEF_RES_W
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              start;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              done;
  logic [RES_W-1:0]  result;
  logic              res_valid;
  logic              res_ready;
  logic [RES_W-1:0]  res_data;

  modport slave (
    input  in_valid, in_a, in_b, done, result, res_ready,
    output in_ready, start, op_a, op_b, res_valid, res_data
  );

  modport master (
    output in_valid, in_a, in_b, done, result, res_ready,
    input  in_ready, start, op_a, op_b, res_valid, res_data
  );

endinterface

// File: rtl/opseq_fifo.sv
// Synchronous FIFO holding packed operand pairs; pointers wrap modulo DEPTH.
module opseq_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/operand_sequencer.sv
// Queues operand pairs and drives the core through one clean start/done cycle each.
// Optional WAIT-state watchdog enabled by defining OPSEQ_TIMEOUT_EN.
module operand_sequencer
  import opseq_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned RES_W       = DEF_RES_W,
  parameter int unsigned DEPTH       = DEF_DEPTH,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                   clk,
  input  logic                   rst,
  opseq_if.slave                 bus,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   err
);

  opseq_state_t state, state_n;

  logic [DATA_W-1:0]   op_a_q, op_b_q;
  logic [RES_W-1:0]    res_q;
  logic [2*DATA_W-1:0] fifo_rdata;
  logic                fifo_full, fifo_empty;
  logic                push, pop, cap_res, wd_expired, timeout;

  assign push         = bus.in_valid && !fifo_full;
  assign bus.in_ready = !fifo_full;

  opseq_fifo #(
    .WIDTH (2 * DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({bus.in_a, bus.in_b}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    cap_res = 1'b0;
    timeout = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_n = ST_ISSUE;
        end
      end
      ST_ISSUE: state_n = ST_WAIT;
      ST_WAIT: begin
        // done only counts here; pulses in any other state are dropped
        if (bus.done) begin
          cap_res = 1'b1;
          state_n = ST_HOLD;
        end else if (wd_expired) begin
          timeout = 1'b1;
          state_n = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.res_ready) state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      op_a_q <= '0;
      op_b_q <= '0;
      res_q  <= '0;
    end else begin
      state <= state_n;
      if (pop) begin
        op_a_q <= fifo_rdata[2*DATA_W-1:DATA_W];
        op_b_q <= fifo_rdata[DATA_W-1:0];
      end
      if (cap_res)      res_q <= bus.result;
      else if (timeout) res_q <= '0;
    end
  end

`ifdef OPSEQ_TIMEOUT_EN
  localparam int unsigned WDW = $clog2(TIMEOUT_CYC + 1);

  logic [WDW-1:0] wd_cnt;
  logic           err_q;

  // Held at zero outside WAIT, so every WAIT entry starts a fresh count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state != ST_WAIT) wd_cnt <= '0;
      else                  wd_cnt <= wd_cnt + WDW'(1);
      if (timeout) err_q <= 1'b1;
    end
  end

  assign wd_expired = (state == ST_WAIT) && (wd_cnt == WDW'(TIMEOUT_CYC - 1));
  assign err        = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign wd_expired         = 1'b0;
  assign err                = 1'b0;
`endif

  assign bus.start     = (state == ST_ISSUE);
  assign bus.res_valid = (state == ST_HOLD);
  assign bus.op_a      = op_a_q;
  assign bus.op_b      = op_b_q;
  assign bus.res_data  = res_q;
  assign busy          = (state != ST_IDLE);

endmodule
